// File: rtl/eth_tx_axis_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_axis_arbiter
//  Purpose  : Frame-granular round-robin arbiter that shares one AXI-Stream
//             TX datapath between NUM_SRC frame sources. The grant is locked
//             from the first beat to the tlast beat of a frame. The output
//             stage is registered. tkeep legality is checked on every
//             accepted beat.
//  Ports    : i_clk, i_reset_n (sync, active low)
//             i_s_tvalid/tdata/tkeep/tlast, o_s_tready : per-source slave side
//             o_m_tvalid/tdata/tkeep/tlast, i_m_tready : registered master side
//             o_grant (one-hot, 0 when idle), o_busy, o_err_keep (pulse)
//             o_frame_cnt, o_err_cnt : only with ETH_TX_ARB_STATS_EN defined
//  Options  : `define ETH_TX_ARB_STATS_EN adds per-source frame counters and
//             a saturating tkeep error counter.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_tx_axis_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 64
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [NUM_SRC-1:0]           i_s_tvalid,
  input  logic [NUM_SRC*DATA_W-1:0]    i_s_tdata,
  input  logic [NUM_SRC*DATA_W/8-1:0]  i_s_tkeep,
  input  logic [NUM_SRC-1:0]           i_s_tlast,
  output logic [NUM_SRC-1:0]           o_s_tready,
  output logic                         o_m_tvalid,
  output logic [DATA_W-1:0]            o_m_tdata,
  output logic [DATA_W/8-1:0]          o_m_tkeep,
  output logic                         o_m_tlast,
  input  logic                         i_m_tready,
  output logic [NUM_SRC-1:0]           o_grant,
  output logic                         o_busy,
`ifdef ETH_TX_ARB_STATS_EN
  output logic [NUM_SRC*16-1:0]        o_frame_cnt,
  output logic [15:0]                  o_err_cnt,
`endif
  output logic                         o_err_keep
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W:0] NUM_SRC_W = (IDX_W+1)'(NUM_SRC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FWD  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  grant_idx, grant_nxt, last_grant, rr_pick;
  logic [IDX_W:0]    rr_sum;
  logic              any_req;

  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep, keep_inc;
  logic              fwd_ready, accept, keep_legal;

  // Round-robin search. Offsets are walked from farthest to nearest so the
  // requester closest after last_grant is the one left in rr_pick.
  always_comb begin
    rr_pick = last_grant;
    any_req = 1'b0;
    rr_sum  = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      rr_sum = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (rr_sum >= NUM_SRC_W) rr_sum = rr_sum - NUM_SRC_W;
      if (i_s_tvalid[rr_sum[IDX_W-1:0]]) begin
        any_req = 1'b1;
        rr_pick = rr_sum[IDX_W-1:0];
      end
    end
  end

  // Mux of the granted source's slave-side signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_valid = i_s_tvalid[k];
        sel_last  = i_s_tlast[k];
        sel_data  = i_s_tdata[k*DATA_W +: DATA_W];
        sel_keep  = i_s_tkeep[k*KEEP_W +: KEEP_W];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign fwd_ready = (state == ST_FWD) && (!o_m_tvalid || i_m_tready);
  assign accept    = fwd_ready && sel_valid;

  // Last beat: non-zero and contiguous from bit 0 (k & (k+1) == 0 wraps for
  // all ones). Non-last beats must be full.
  assign keep_inc   = sel_keep + KEEP_W'(1);
  assign keep_legal = sel_last ? ((sel_keep != '0) && ((sel_keep & keep_inc) == '0))
                               : (&sel_keep);

  // Next-state and per-state outputs.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_idx;
    o_s_tready = '0;
    o_grant    = '0;
    o_busy     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_nxt = rr_pick;
          state_nxt = ST_FWD;
        end
      end
      ST_FWD: begin
        o_busy             = 1'b1;
        o_grant[grant_idx] = 1'b1;
        if (fwd_ready) o_s_tready[grant_idx] = 1'b1;
        if (accept && sel_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
      o_m_tvalid <= 1'b0;
      o_m_tdata  <= '0;
      o_m_tkeep  <= '0;
      o_m_tlast  <= 1'b0;
      o_err_keep <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      if (accept && sel_last) last_grant <= grant_idx;
      if (accept) begin
        o_m_tvalid <= 1'b1;
        o_m_tdata  <= sel_data;
        o_m_tkeep  <= sel_keep;
        o_m_tlast  <= sel_last;
        o_err_keep <= !keep_legal;
      end else begin
        if (i_m_tready) o_m_tvalid <= 1'b0;
        o_err_keep <= 1'b0;
      end
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic [NUM_SRC*16-1:0] frame_cnt;
  logic [15:0]           err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (accept && sel_last && (grant_idx == IDX_W'(k)))
          frame_cnt[k*16 +: 16] <= frame_cnt[k*16 +: 16] + 16'd1;
      end
      if (o_err_keep && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt;
  assign o_err_cnt   = err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_axis_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_tx_axis_arbiter
//  Purpose  : Scoreboard bench for eth_tx_axis_arbiter. Frames are queued per
//             source; a round-robin reference model over pending frames
//             predicts grant order and the output beat stream, and a monitor
//             compares every output beat and the interface invariants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_axis_arbiter;
  localparam int NS = 3;
  localparam int DW = 64;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0]    s_tvalid, s_tready, s_tlast;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic             m_tvalid, m_tlast, m_tready, busy, err_keep;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [NS-1:0]    grant;
`ifdef ETH_TX_ARB_STATS_EN
  logic [NS*16-1:0] frame_cnt;
  logic [15:0]      err_cnt;
`endif

  eth_tx_axis_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_s_tvalid  (s_tvalid),
    .i_s_tdata   (s_tdata),
    .i_s_tkeep   (s_tkeep),
    .i_s_tlast   (s_tlast),
    .o_s_tready  (s_tready),
    .o_m_tvalid  (m_tvalid),
    .o_m_tdata   (m_tdata),
    .o_m_tkeep   (m_tkeep),
    .o_m_tlast   (m_tlast),
    .i_m_tready  (m_tready),
    .o_grant     (grant),
    .o_busy      (busy),
`ifdef ETH_TX_ARB_STATS_EN
    .o_frame_cnt (frame_cnt),
    .o_err_cnt   (err_cnt),
`endif
    .o_err_keep  (err_keep)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          e;
  } beat_t;

  beat_t         srcq[NS][$];    // beats still to be driven per source
  beat_t         mq[NS][$];      // model copy of pending beats
  int            fl_q[NS][$];    // model: pending frame lengths per source
  beat_t         exp_q[$];       // expected output beat stream
  logic [NS-1:0] exp_grant_q[$]; // expected grant sequence
  int            model_last;
  int            model_frames[NS];
  int            model_errs;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit keep_ok(input logic [KW-1:0] k, input logic last);
    if (!last) return (k == {KW{1'b1}});
    for (int n = 1; n <= KW; n++) if (k == KW'((1 << n) - 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_frame(input int src, input int n, input logic [KW-1:0] mid_k,
                           input logic [KW-1:0] last_k);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = {$urandom, $urandom};
      b.l = (i == n - 1);
      b.k = b.l ? last_k : mid_k;
      b.e = !keep_ok(b.k, b.l);
      srcq[src].push_back(b);
      mq[src].push_back(b);
    end
    fl_q[src].push_back(n);
  endtask

  // Plays out arbitration over all pending frames: the next frame always comes
  // from the first source after the previous winner that has one queued.
  task automatic model_arbitrate();
    int sel, n, c;
    beat_t b;
    forever begin
      sel = -1;
      for (int off = 1; off <= NS && sel < 0; off++) begin
        c = (model_last + off) % NS;
        if (fl_q[c].size() > 0) sel = c;
      end
      if (sel < 0) break;
      n = fl_q[sel].pop_front();
      exp_grant_q.push_back(NS'(1 << sel));
      for (int i = 0; i < n; i++) begin
        b = mq[sel].pop_front();
        exp_q.push_back(b);
        model_errs += int'(b.e);
      end
      model_frames[sel]++;
      model_last = sel;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      srcq[k].delete();
      mq[k].delete();
      fl_q[k].delete();
      model_frames[k] = 0;
    end
    exp_q.delete();
    exp_grant_q.delete();
    model_last = NS - 1;
    model_errs = 0;
  endtask

  // ---------------------------------------------------------------- driver
  bit            in_frame[NS];
  bit            bubble_en = 1'b0;
  int            tr_mode = 0;     // 0: always ready, 1: random, 2: scripted
  int            acc_cnt[NS];
  logic [NS-1:0] fire;
  beat_t         db;

  initial begin
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; m_tready = 1'b1;
    for (int k = 0; k < NS; k++) begin in_frame[k] = 1'b0; acc_cnt[k] = 0; end
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NS; k++) begin
        if (fire[k] && srcq[k].size() > 0) begin
          db = srcq[k].pop_front();
          in_frame[k] = !db.l;
          acc_cnt[k]++;
        end
        if (srcq[k].size() > 0) begin
          s_tvalid[k] = (in_frame[k] && bubble_en) ? ($urandom_range(0, 3) != 0) : 1'b1;
          s_tdata[k*DW +: DW] = srcq[k][0].d;
          s_tkeep[k*KW +: KW] = srcq[k][0].k;
          s_tlast[k]          = srcq[k][0].l;
        end else begin
          s_tvalid[k] = 1'b0;
        end
      end
      if (tr_mode == 1)      m_tready = ($urandom_range(0, 2) != 0);
      else if (tr_mode == 0) m_tready = 1'b1;
    end
  end

  // --------------------------------------------------------------- monitor
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd;
  logic [KW-1:0] pk;
  logic [NS-1:0] pg = '0, exp_tr;
  int            gap = 0, frames_seen = 0, pop_cnt = 0, lat_start = 0;
  bit            gap_en = 1'b0, lat_en = 1'b0, lat_done = 1'b0;
  beat_t         mb;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pg = '0; gap = 0;
    end else begin
      exp_tr = (busy && (!m_tvalid || m_tready)) ? grant : '0;
      chk("s_tready", 64'(s_tready), 64'(exp_tr));
      chk("busy_vs_grant", 64'(busy), 64'(grant != '0));
      chk("grant_onehot", 64'($onehot0(grant)), 64'd1);
      if (pv && !pr) begin
        chk("stall_tvalid", 64'(m_tvalid), 64'd1);
        chk("stall_tdata", m_tdata, pd);
        chk("stall_tkeep", 64'(m_tkeep), 64'(pk));
        chk("stall_tlast", 64'(m_tlast), 64'(pl));
        chk("stall_err_keep", 64'(err_keep), 64'd0);
      end else if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %h expected none", m_tdata);
        end else begin
          mb = exp_q.pop_front();
          chk("tdata", m_tdata, mb.d);
          chk("tkeep", 64'(m_tkeep), 64'(mb.k));
          chk("tlast", 64'(m_tlast), 64'(mb.l));
          chk("err_keep", 64'(err_keep), 64'(mb.e));
          pop_cnt++;
          if (lat_en && !lat_done) begin
            chk("first_beat_latency", 64'(cyc - lat_start), 64'd2);
            lat_done = 1'b1;
          end
        end
      end else begin
        chk("err_keep_idle", 64'(err_keep), 64'd0);
      end
      if (pg == '0 && grant != '0) begin
        if (exp_grant_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_grant: got %h expected none", grant);
        end else begin
          chk("grant_order", 64'(grant), 64'(exp_grant_q.pop_front()));
        end
        if (gap_en && frames_seen > 0) chk("idle_gap", 64'(gap), 64'd1);
        frames_seen++;
      end else if (pg != '0 && grant != '0) begin
        chk("grant_hold", 64'(grant), 64'(pg));
      end
      gap = busy ? 0 : gap + 1;
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pk = m_tkeep; pl = m_tlast; pg = grant;
    end
  end

  // ----------------------------------------------------------------- main
  task automatic wait_done(input string name);
    int n = 0;
    while (!(srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 &&
             exp_q.size() == 0 && !m_tvalid && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, exp_q.size());
    end
    chk({name, "_grants_left"}, 64'(exp_grant_q.size()), 64'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({name, "_m_tdata"}, m_tdata, 64'd0);
    chk({name, "_m_tkeep"}, 64'(m_tkeep), 64'd0);
    chk({name, "_m_tlast"}, 64'(m_tlast), 64'd0);
    chk({name, "_grant"}, 64'(grant), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_err_keep"}, 64'(err_keep), 64'd0);
    chk({name, "_s_tready"}, 64'(s_tready), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    model_reset();
    for (int k = 0; k < NS; k++) in_frame[k] = 1'b0;
    s_tvalid = '0;
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
  endtask

`ifdef ETH_TX_ARB_STATS_EN
  task automatic check_stats(input string name);
    for (int k = 0; k < NS; k++)
      chk({name, "_frame_cnt"}, 64'(frame_cnt[k*16 +: 16]), 64'(model_frames[k] & 16'hFFFF));
    chk({name, "_err_cnt"}, 64'(err_cnt), 64'(model_errs > 65535 ? 65535 : model_errs));
  endtask
`endif

  int base;
  logic [KW-1:0] rk_mid, rk_last;

  initial begin
    model_reset();
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Single source, 6 beats, last keep 03
    @(negedge clk);
    add_frame(0, 6, 8'hFF, 8'h03);
    model_arbitrate();
    lat_en = 1'b1;
    @(posedge clk);
    #2 lat_start = cyc;
    wait_done("single");
    lat_en = 1'b0;

    // Round robin with all sources requesting continuously
    pulse_reset();
    @(negedge clk);
    gap_en = 1'b1;
    frames_seen = 0;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < NS; s++) add_frame(s, 10, 8'hFF, 8'hFF);
    model_arbitrate();
    wait_done("round_robin");
    gap_en = 1'b0;
`ifdef ETH_TX_ARB_STATS_EN
    check_stats("rr");
`endif

    // Backpressure: downstream stalls 4 cycles mid-frame
    @(negedge clk);
    tr_mode = 2;
    base = pop_cnt;
    add_frame(2, 10, 8'hFF, 8'hFF);
    model_arbitrate();
    for (int n = 0; n < 200 && pop_cnt < base + 4; n++) @(negedge clk);
    @(posedge clk);
    #1 m_tready = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_tready = 1'b1;
    wait_done("backpressure");
    chk("backpressure_beats", 64'(pop_cnt - base), 64'd10);
    tr_mode = 0;

    // Illegal and boundary tkeep values
    @(negedge clk);
    add_frame(0, 3, 8'h7F, 8'h05);
    add_frame(1, 1, 8'hFF, 8'h00);
    add_frame(2, 2, 8'hFF, 8'h01);
    model_arbitrate();
    wait_done("tkeep");

    // Randomized traffic with source bubbles and downstream backpressure
    @(negedge clk);
    bubble_en = 1'b1;
    tr_mode = 1;
    for (int f = 0; f < 15; f++) begin
      rk_mid  = ($urandom_range(0, 4) == 0) ? KW'($urandom) : 8'hFF;
      rk_last = ($urandom_range(0, 3) == 0) ? KW'($urandom)
                                            : KW'((1 << $urandom_range(1, KW)) - 1);
      add_frame($urandom_range(0, NS - 1), $urandom_range(1, 8), rk_mid, rk_last);
    end
    model_arbitrate();
    wait_done("random");
    bubble_en = 1'b0;
    tr_mode = 0;
`ifdef ETH_TX_ARB_STATS_EN
    check_stats("random");
`endif

    // Reset in the middle of a source-1 frame
    @(negedge clk);
    base = acc_cnt[1];
    add_frame(1, 6, 8'hFF, 8'hFF);
    model_arbitrate();
    for (int n = 0; n < 200 && acc_cnt[1] < base + 2; n++) @(negedge clk);
    chk("midframe_beats_accepted", 64'(acc_cnt[1] - base), 64'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    model_reset();
    for (int k = 0; k < NS; k++) in_frame[k] = 1'b0;
    s_tvalid = '0;
    @(negedge clk);
    check_zero_outputs("midframe_reset");
    rst_n = 1'b1;
    @(negedge clk);
    add_frame(2, 4, 8'hFF, 8'h0F);
    add_frame(1, 4, 8'hFF, 8'h0F);
    add_frame(0, 4, 8'hFF, 8'h0F);
    model_arbitrate();
    wait_done("after_reset");

`ifdef ETH_TX_ARB_STATS_EN
    // Counter wrap from FFFF to 0
    @(negedge clk);
    dut.frame_cnt[15:0] = 16'hFFFF;
    model_frames[0] = 16'hFFFF;
    add_frame(0, 2, 8'hFF, 8'hFF);
    model_arbitrate();
    wait_done("wrap");
    check_stats("wrap");
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/eth_tx_axis_arbiter.md
Name: eth_tx_axis_arbiter

Overview:
- Frame-granular round-robin arbiter sharing the 64-bit AXI-Stream TX datapath of the 10G Ethernet core between NUM_SRC frame sources (e.g. ARP responder, ICMP echo, UDP app).
- Locks the grant from the first beat to the tlast beat of a frame, so frames never interleave.
- Output is registered, and tdata, tkeep and tlast pass through unchanged.
- Also checks tkeep legality per beat.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8).
- DATA_W, 64, tdata width; tkeep width is DATA_W/8.

Ports:
- i_clk  in  1  core clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_s_tvalid  in  NUM_SRC  per-source tvalid.
- i_s_tdata  in  NUM_SRC*DATA_W  per-source tdata; source k occupies [k*DATA_W +: DATA_W].
- i_s_tkeep  in  NUM_SRC*DATA_W/8  per-source tkeep, same slicing.
- i_s_tlast  in  NUM_SRC  per-source tlast.
- o_s_tready  out  NUM_SRC  per-source tready (combinational).
- o_m_tvalid  out  1  output tvalid (registered).
- o_m_tdata  out  DATA_W  output tdata (registered).
- o_m_tkeep  out  DATA_W/8  output tkeep (registered).
- o_m_tlast  out  1  output tlast (registered).
- i_m_tready  in  1  downstream tready.
- o_grant  out  NUM_SRC  one-hot current grant; 0 when idle.
- o_busy  out  1  high while a frame is in progress.
- o_err_keep  out  1  one-cycle pulse on an illegal tkeep.

Behaviour:
- Reset (i_reset_n low at i_clk edge):
  - All outputs go to 0; state goes to IDLE.
  - last_grant = NUM_SRC-1, so source 0 has first priority.
  - A frame in flight is dropped silently; sources must restart it.
- States IDLE and FWD.
- IDLE:
  - o_s_tready is all 0.
  - If any i_s_tvalid is high, select the first requester searching from (last_grant+1) mod NUM_SRC upward with wrap. Register it in grant and go to FWD.
  - No requesters means stay in IDLE.
- FWD:
  - o_s_tready[g] = !o_m_tvalid || i_m_tready; o_s_tready of all other sources is 0.
  - Beat accept = i_s_tvalid[g] && o_s_tready[g].
  - On accept, load the output register with source g's tdata/tkeep/tlast and set o_m_tvalid = 1.
  - If the output register was not reloaded and i_m_tready is high, clear o_m_tvalid.
  - On accept with tlast = 1, set last_grant = g and return to IDLE.
- Latency:
  - A request in IDLE gives grant on the next edge; the first beat is accepted in the following cycle.
  - The first output beat is valid 2 cycles after tvalid rises.
  - Steady state is 1 beat per cycle.
  - There is one forced idle-arbitration cycle between consecutive frames.
- Stall: while o_m_tvalid && !i_m_tready, all output signals hold stable (AXI rule).
- Sources not granted are never accepted, even if their tvalid is high.
- Source tvalid dropping mid-frame: the grant is held, output bubbles are allowed, and no timeout applies.
- o_busy = (state == FWD).
- o_grant = one-hot(g) in FWD, otherwise 0.
- tkeep check, evaluated on each accepted beat; o_err_keep pulses the next cycle, aligned with the output beat:
  - A non-last beat must have tkeep all ones.
  - A last beat must be non-zero and contiguous from bit 0, i.e. (k & (k+1)) == 0.
  - A violating beat is still forwarded unchanged.
- Single-beat frame (tlast on the first beat) is legal.

Optional Feature:
- Macro: ETH_TX_ARB_STATS_EN.
- When defined:
  - Adds output o_frame_cnt, width NUM_SRC*16: per-source 16-bit counters of completed frames, incremented on an accepted tlast beat.
  - Counters wrap from 16'hFFFF to 0 and are cleared by reset.
  - Adds output o_err_cnt, width 16: counts o_err_keep pulses and saturates at 16'hFFFF.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then single source: source 0 sends 6 beats (tkeep FF×5, last 8'h03).
  - Outputs are 0 during reset and o_grant = 3'b001.
  - The first output beat appears 2 cycles after tvalid and matches bit-exactly.
  - o_m_tlast is high only on beat 6.
  - o_err_keep stays 0.
- All three sources hold tvalid continuously, 10-beat frames:
  - Grant order is 0, 1, 2, 0.
  - Frames never interleave.
  - There is exactly 1 idle cycle between frames.
- Backpressure: i_m_tready low for 4 cycles mid-frame.
  - o_m_tdata, o_m_tkeep and o_m_tlast are stable.
  - o_s_tready[g] is 0 after the output register fills.
  - No beat is lost or duplicated; all 10 beats are compared.
- Illegal tkeep:
  - A non-last beat with tkeep 8'h7F gives an o_err_keep pulse.
  - A last beat with tkeep 8'h05 gives a pulse.
  - A last beat with tkeep 8'h00 gives a pulse.
  - A last beat with tkeep 8'h01 gives no pulse.
  - Data is forwarded unchanged in every case.
- Reset mid-frame: assert i_reset_n = 0 at beat 3 of a source-1 frame.
  - All outputs go to 0 and o_grant = 0.
  - After release, source 0 wins arbitration first.
- With ETH_TX_ARB_STATS_EN:
  - After the round-robin test (3 frames per source), o_frame_cnt reads 3/3/3.
  - Preloading a counter to 16'hFFFF and completing one more frame wraps it to 0.
